// File: rtl/instr_fetch_responder.sv
// Instruction-fetch responder: accepts a PC, reads a word from a fixed-latency
// memory (or faults), and holds the response until the consumer takes it.
module instr_fetch_responder #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] NOP_INSTR   = 32'h00000013,
  localparam int         AW          = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  input  logic          flush,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_addr,
  output logic          rsp_fault,
  output logic          mem_en,
  output logic [AW-1:0] mem_addr,
  input  logic [31:0]   mem_rdata
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  logic [1:0] state;
  logic [3:0] cnt;
  logic       accept;
  logic       fault;

  assign req_ready = ~flush & ((state == IDLE) | ((state == RESP) & rsp_ready));
  assign accept    = req_valid & req_ready;
  // Full 30-bit word index compare so high addresses cannot alias into memory.
  assign fault     = (req_addr[1:0] != 2'b00) |
                     ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));
  assign rsp_valid = (state == RESP);
  assign mem_en    = (state == WAIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rsp_instr <= NOP_INSTR;
      rsp_addr  <= '0;
      rsp_fault <= 1'b0;
      mem_addr  <= '0;
    end else if (flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (accept) begin
      rsp_addr <= req_addr;
      cnt      <= WAIT_INIT;
      if (fault) begin
        state     <= RESP;
        rsp_fault <= 1'b1;
        rsp_instr <= NOP_INSTR;
      end else begin
        state    <= WAIT;
        mem_addr <= req_addr[AW+1:2];
      end
    end else begin
      case (state)
        WAIT: begin
          if (cnt == 4'd1) begin
            rsp_instr <= mem_rdata;
            rsp_fault <= 1'b0;
            cnt       <= '0;
            state     <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    if (rsp_ready) state <= IDLE;
        IDLE:    ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Randomized bench for instr_fetch_responder against a transaction-level model:
// one outstanding fetch with the cycle its response becomes visible.
module tb_instr_fetch_responder;
  localparam int          MEMW = 1024;
  localparam int          WC   = 2;
  localparam int          AW   = $clog2(MEMW);
  localparam logic [31:0] NOP  = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [31:0]   req_addr = '0;
  logic          flush = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_instr;
  logic [31:0]   rsp_addr;
  logic          rsp_fault;
  logic          mem_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata;

  instr_fetch_responder #(.MEM_WORDS(MEMW), .WAIT_CYCLES(WC), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .flush(flush), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr), .rsp_addr(rsp_addr), .rsp_fault(rsp_fault),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Reference model: at most one fetch pending, visible from cycle m_ready_at.
  logic [31:0] mem [MEMW];
  int          cyc = 0;
  logic        m_busy = 1'b0;
  logic        m_fault = 1'b0;
  logic [31:0] m_addr = '0;
  logic [31:0] m_instr = '0;
  int          m_ready_at = 0;
  int          n_tests = 0;
  int          n_fail = 0;

  // Real data only in the last wait cycle; junk otherwise to expose mistimed capture.
  assign mem_rdata = (m_busy && !m_fault && cyc == m_ready_at - 1) ?
                     mem[m_addr[AW+1:2]] : (32'hBAD0_0000 ^ 32'(cyc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] a, input logic fl, input logic rr);
    logic exp_rv, exp_me, exp_rdy, f;
    req_valid = v; req_addr = a; flush = fl; rsp_ready = rr;
    @(negedge clk);
    exp_rv  = m_busy && cyc >= m_ready_at;
    exp_me  = m_busy && !m_fault && cyc < m_ready_at;
    exp_rdy = !fl && (!m_busy || (exp_rv && rr));
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    chk("mem_en", 32'(mem_en), 32'(exp_me));
    if (exp_me) chk("mem_addr", 32'(mem_addr), 32'(m_addr[31:2]));
    if (exp_rv) begin
      chk("rsp_instr", rsp_instr, m_instr);
      chk("rsp_addr", rsp_addr, m_addr);
      chk("rsp_fault", 32'(rsp_fault), 32'(m_fault));
    end
    @(posedge clk);
    #1;
    cyc++;
    if (fl) m_busy = 1'b0;
    else if (v && exp_rdy) begin
      f          = (a[1:0] != 2'b00) || ({2'b00, a[31:2]} >= 32'(MEMW));
      m_busy     = 1'b1;
      m_fault    = f;
      m_addr     = a;
      m_instr    = f ? NOP : mem[a[AW+1:2]];
      m_ready_at = cyc + (f ? 0 : WC);
    end else if (exp_rv && rr) m_busy = 1'b0;
  endtask

  task automatic do_reset();
    req_valid = 1'b0; flush = 1'b0; rsp_ready = 1'b0; req_addr = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_mem_en", 32'(mem_en), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_instr", rsp_instr, NOP);
    chk("rst_addr", rsp_addr, 32'd0);
    chk("rst_fault", 32'(rsp_fault), 32'd0);
    m_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_addr();
    int r = $urandom_range(0, 9);
    if (r < 7)  return {20'd0, 10'($urandom_range(0, MEMW - 1)), 2'b00};
    if (r == 7) return {20'd0, 10'($urandom_range(0, MEMW - 1)), 2'($urandom_range(1, 3))};
    if (r == 8) return 32'(MEMW * 4) + 32'($urandom_range(0, 255) * 4);
    return $urandom;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < MEMW; i++) mem[i] = (32'(i) * 32'h9E3779B1) ^ 32'h5A5A_0000;
    mem[4] = 32'h00500093;
    #2;
    do_reset();

    // Basic fetch of 0x10, then hold the response, then back-to-back accept of 0x14.
    step(1'b1, 32'h10, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("r35_instr", rsp_instr, 32'h00500093);
    chk("r35_addr", rsp_addr, 32'h10);
    chk("r35_fault", 32'(rsp_fault), 32'd0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b1, 32'h14, 1'b0, 1'b1);
    chk("r37_mem_en", 32'(mem_en), 32'd1);
    chk("r37_mem_addr", 32'(mem_addr), 32'd5);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);

    // Misaligned and out-of-range fetches fault with a NOP.
    step(1'b1, 32'h6, 1'b0, 1'b0);
    chk("r36_valid", 32'(rsp_valid), 32'd1);
    chk("r36_fault", 32'(rsp_fault), 32'd1);
    chk("r36_instr", rsp_instr, NOP);
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h1000, 1'b0, 1'b1);
    chk("r36b_fault", 32'(rsp_fault), 32'd1);
    step(1'b1, 32'h4000_1000, 1'b0, 1'b1);
    chk("alias_fault", 32'(rsp_fault), 32'd1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush in the first wait cycle, then a fresh fetch.
    step(1'b1, 32'h20, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 32'h24, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("r38_instr", rsp_instr, mem[9]);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Flush wins over a simultaneous request in idle.
    step(1'b1, 32'h40, 1'b1, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    // Reset mid-wait.
    step(1'b1, 32'h30, 1'b0, 1'b1);
    do_reset();
    step(1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 32'h0, 1'b0, 1'b1);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) do_reset();
      step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 19) == 0,
           $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_fetch_responder.md
INSTR_FETCH_RESPONDER -- requirements
Module: instr_fetch_responder

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 1024, number of 32-bit instruction words backing the responder.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, legal range 1..15, memory read latency in cycles.
REQ-003 SHALL have parameter NOP_INSTR, default 32'h00000013, instruction returned on a fault.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req_valid  input  1  the fetch side presents a PC.
REQ-007 req_ready  output  1  the responder accepts the PC this cycle.
REQ-008 req_addr  input  32  fetch byte address (the PC).
REQ-009 flush  input  1  redirect; discards any in-flight or held fetch.
REQ-010 rsp_valid  output  1  instruction response available.
REQ-011 rsp_ready  input  1  consumer takes the response this cycle.
REQ-012 rsp_instr  output  32  fetched instruction word.
REQ-013 rsp_addr  output  32  byte address the response belongs to.
REQ-014 rsp_fault  output  1  misaligned or out-of-range fetch.
REQ-015 mem_en  output  1  memory read enable.
REQ-016 mem_addr  output  clog2(MEM_WORDS)  word index, equal to req_addr[31:2] of the accepted request.
REQ-017 mem_rdata  input  32  read data, valid in the last WAIT cycle.

Function
REQ-018 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-019 Handshake: req_ready = ~flush & (IDLE | (RESP & rsp_ready)); a request is accepted on an edge where req_valid & req_ready.
REQ-020 Acceptance SHALL latch req_addr into rsp_addr and set wait counter to WAIT_CYCLES.
REQ-021 Fault on acceptance if req_addr[1:0] != 0 or req_addr[31:2] >= MEM_WORDS; next state RESP, rsp_fault=1, rsp_instr=NOP_INSTR, no mem_en pulse.
REQ-022 Non-fault acceptance: next state WAIT; mem_en=1 and mem_addr stable throughout every WAIT cycle.
REQ-023 In WAIT the counter decrements each cycle; on the edge ending the cycle in which the counter equals 1, mem_rdata SHALL be captured into rsp_instr, rsp_fault=0, state goes to RESP.
REQ-024 Latency: non-fault rsp_valid rises WAIT_CYCLES edges after the accepting edge; fault rsp_valid rises 1 edge after.
REQ-025 In RESP, rsp_valid=1, and rsp_instr, rsp_addr, rsp_fault SHALL hold stable until rsp_valid & rsp_ready.
REQ-026 RESP with rsp_ready=1 and no new acceptance: next state IDLE, rsp_valid=0 next cycle.
REQ-027 RESP with rsp_ready=1 and a simultaneous acceptance: go directly to WAIT or RESP(fault) per REQ-021/022, no idle bubble.
REQ-028 flush=1 on any edge: next state IDLE, counter cleared, rsp_valid=0 next cycle, any held response is dropped, and any concurrent req_valid is ignored (flush has priority).
REQ-029 Memory data returned for a flushed fetch SHALL never appear on rsp_instr.
REQ-030 rsp_valid, mem_en SHALL be 0 in IDLE; mem_en SHALL be 0 in RESP.
REQ-031 Address comparison SHALL use the full 30-bit word index, so addresses above the range never alias into memory.

Reset
REQ-032 rst_n low SHALL immediately (asynchronously) force state IDLE, counter 0, rsp_valid=0, rsp_fault=0, rsp_instr=NOP_INSTR, rsp_addr=0, mem_en=0, mem_addr=0.
REQ-033 Reset asserted mid-WAIT or mid-RESP SHALL abandon the fetch; after release no stale response is presented.
REQ-034 req_ready SHALL be 1 in the first cycle after reset release when flush=0.

Verification
REQ-035 WAIT_CYCLES=2, req_addr=0x10, mem_rdata=0x00500093 -> mem_en=1 with mem_addr=4 for 2 cycles; rsp_valid 2 edges after accept, rsp_instr=0x00500093, rsp_addr=0x10, rsp_fault=0.
REQ-036 req_addr=0x6 -> rsp_valid 1 edge later, rsp_fault=1, rsp_instr=0x00000013, mem_en never asserted; repeat with req_addr=0x1000 (MEM_WORDS=1024) -> same.
REQ-037 rsp_ready held 0 for 5 cycles during RESP -> outputs stable; then rsp_ready=1 with req_valid=1, req_addr=0x14 -> next cycle state WAIT, mem_addr=5, no bubble.
REQ-038 flush=1 in the first WAIT cycle of fetch 0x20 -> rsp_valid stays 0; subsequent fetch 0x24 returns its own data, never data for 0x20.
REQ-039 flush=1 and req_valid=1 on the same edge in IDLE -> request not accepted, req_ready=0 that cycle.
REQ-040 rst_n pulsed low mid-WAIT -> all outputs at reset values immediately, rsp_valid=0 after release, req_ready=1.
